ulpi_phy_emu: RTL

ULPI_PHY_EMU -- requirements
Module: ulpi_phy_emu

---
 rtl/ulpi_pkg.sv | 73 +++++++
 rtl/ulpi_phy_emu_if.sv | 39 +++
 rtl/ulpi_phy_regfile.sv | 45 ++++
 rtl/ulpi_phy_emu.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ulpi_pkg.sv
// ULPI PHY emulator shared types and constants.
// State encoding, TXCMD opcodes, register map and reset values.
package ulpi_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_CMD,
        WR_DATA,
        WR_STP,
        RD_CMD,
        RD_TURN,
        RD_DATA,
        RD_END,
        TX,
        RX_TURN,
        RX_DATA,
        RX_CMD_END,
        RXC_TURN,
        RXC_DATA,
        TURN_BACK
    } ulpi_state_e;

    localparam logic [1:0] OP_SPECIAL = 2'b00;
    localparam logic [1:0] OP_TX      = 2'b01;
    localparam logic [1:0] OP_REGW    = 2'b10;
    localparam logic [1:0] OP_REGR    = 2'b11;

    localparam logic [5:0] ADDR_VID_LO    = 6'h00;
    localparam logic [5:0] ADDR_VID_HI    = 6'h01;
    localparam logic [5:0] ADDR_PID_LO    = 6'h02;
    localparam logic [5:0] ADDR_PID_HI    = 6'h03;
    localparam logic [5:0] ADDR_FUNC_CTRL = 6'h04;
    localparam logic [5:0] ADDR_OTG_CTRL  = 6'h0A;
    localparam logic [5:0] ADDR_FIRST_RW  = 6'h04;

    localparam logic [7:0] VID_LO = 8'h24;
    localparam logic [7:0] VID_HI = 8'h04;
    localparam logic [7:0] PID_LO = 8'h06;
    localparam logic [7:0] PID_HI = 8'h00;

    localparam logic [7:0] FUNC_CTRL_RST = 8'h41;
    localparam logic [7:0] OTG_CTRL_RST  = 8'h06;
    localparam int         FUNC_RESET_BIT = 5;

    localparam int ALIAS_GROUPS = 6;

    localparam logic [1:0] LINE_STATE = 2'b01;
    localparam logic [7:0] RXCMD_IDLE = {6'b000000, LINE_STATE};

    // Set/clear aliases live at base+1/base+2 for bases 0x04,0x07,...,0x13.
    function automatic logic [5:0] reg_base(input logic [5:0] a);
        logic [5:0] b;
        logic [5:0] g;
        b = a;
        for (int i = 0; i < ALIAS_GROUPS; i++) begin
            g = 6'(4 + 3 * i);
            if (a == g + 6'd1 || a == g + 6'd2) b = g;
        end
        return b;
    endfunction

    function automatic logic [7:0] ro_value(input logic [1:0] a);
        logic [7:0] v;
        unique case (a)
            2'd0:    v = VID_LO;
            2'd1:    v = VID_HI;
            2'd2:    v = PID_LO;
            default: v = PID_HI;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ulpi_phy_emu_if.sv
// ULPI bus plus RX packet / RX CMD inject and TX capture streams.
// master = link/test side, slave = PHY emulator.
interface ulpi_phy_emu_if;

    logic       o_dir;
    logic       o_nxt;
    logic       i_stp;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic       i_rx_valid;
    logic [7:0] i_rx_data;
    logic       i_rx_last;
    logic       o_rx_ready;
    logic       i_rxcmd_valid;
    logic [7:0] i_rxcmd;
    logic       o_rxcmd_ready;
    logic       o_tx_valid;
    logic [7:0] o_tx_data;
    logic       o_tx_last;

    modport master (
        input  o_dir, o_nxt, o_data,
        input  o_rx_ready, o_rxcmd_ready,
        input  o_tx_valid, o_tx_data, o_tx_last,
        output i_stp, i_data,
        output i_rx_valid, i_rx_data, i_rx_last,
        output i_rxcmd_valid, i_rxcmd
    );

    modport slave (
        output o_dir, o_nxt, o_data,
        output o_rx_ready, o_rxcmd_ready,
        output o_tx_valid, o_tx_data, o_tx_last,
        input  i_stp, i_data,
        input  i_rx_valid, i_rx_data, i_rx_last,
        input  i_rxcmd_valid, i_rxcmd
    );

endinterface

// File: rtl/ulpi_phy_regfile.sv
// ULPI register file: 64 x 8, read-only ID bytes, set/clear aliases.
// Function-control Reset bit self-clears one cycle after being set.
module ulpi_phy_regfile
    import ulpi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [7:0] wdata,
    input  logic [5:0] raddr,
    output logic [7:0] rdata,
    output logic       phy_reset
);

    logic [7:0] regs [64];
    logic [5:0] wbase;

    assign wbase = reg_base(waddr);
    assign phy_reset = regs[ADDR_FUNC_CTRL][FUNC_RESET_BIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
            regs[ADDR_FUNC_CTRL] <= FUNC_CTRL_RST;
            regs[ADDR_OTG_CTRL]  <= OTG_CTRL_RST;
        end else begin
            if (phy_reset) regs[ADDR_FUNC_CTRL][FUNC_RESET_BIT] <= 1'b0;
            if (we && waddr >= ADDR_FIRST_RW) begin
                if (waddr == wbase)
                    regs[wbase] <= wdata;
                else if (waddr == wbase + 6'd1)
                    regs[wbase] <= regs[wbase] | wdata;
                else
                    regs[wbase] <= regs[wbase] & ~wdata;
            end
        end
    end

    always_comb begin
        rdata = regs[reg_base(raddr)];
        if (raddr < ADDR_FIRST_RW) rdata = ro_value(raddr[1:0]);
    end

endmodule

// File: rtl/ulpi_phy_emu.sv
// ULPI PHY emulator: TXCMD decode, register access, TX capture,
// RX packet and RX CMD injection with bus turnaround.
module ulpi_phy_emu
    import ulpi_pkg::*;
(
    input logic           i_clk,
    input logic           i_rst,
    ulpi_phy_emu_if.slave bus
);

    ulpi_state_e state;
    ulpi_state_e state_n;

    logic [5:0] addr_q;
    logic [7:0] wdata_q;
    logic       tx_valid_q;
    logic [7:0] tx_data_q;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       phy_reset;
    logic [1:0] op;
    logic       cmd_ok;

    assign op     = bus.i_data[7:6];
    assign cmd_ok = !bus.i_rx_valid && !bus.i_rxcmd_valid;

    ulpi_phy_regfile u_regs (
        .clk       (i_clk),
        .rst       (i_rst),
        .we        (reg_we),
        .waddr     (addr_q),
        .wdata     (wdata_q),
        .raddr     (addr_q),
        .rdata     (reg_rdata),
        .phy_reset (phy_reset)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE) addr_q <= bus.i_data[5:0];
            if (state == WR_DATA) wdata_q <= bus.i_data;
            tx_valid_q <= (state == IDLE && state_n == TX) ||
                          (state == TX && !bus.i_stp);
            // PID byte goes out first, then each byte the link drove.
            tx_data_q <= (state == IDLE) ?
                         {~bus.i_data[3:0], bus.i_data[3:0]} :
                         bus.i_data;
        end
    end

    assign bus.o_tx_valid = tx_valid_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_last  = tx_valid_q && state == TX && bus.i_stp;

    always_comb begin
        state_n           = state;
        bus.o_dir         = 1'b0;
        bus.o_nxt         = 1'b0;
        bus.o_data        = 8'h00;
        bus.o_rx_ready    = 1'b0;
        bus.o_rxcmd_ready = 1'b0;
        reg_we            = 1'b0;
        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    bus.i_rx_valid:
                        state_n = RX_TURN;
                    !bus.i_rx_valid && bus.i_rxcmd_valid:
                        state_n = RXC_TURN;
                    cmd_ok && op == OP_REGW:
                        state_n = WR_CMD;
                    cmd_ok && op == OP_REGR:
                        state_n = RD_CMD;
                    cmd_ok && op == OP_TX:
                        state_n = TX;
                    default: ;
                endcase
            end
            WR_CMD: begin
                bus.o_nxt = 1'b1;
                state_n   = WR_DATA;
            end
            WR_DATA: begin
                bus.o_nxt = 1'b1;
                state_n   = WR_STP;
            end
            WR_STP: begin
                reg_we  = bus.i_stp;
                state_n = IDLE;
            end
            RD_CMD: begin
                bus.o_nxt = 1'b1;
                state_n   = RD_TURN;
            end
            RD_TURN: begin
                bus.o_dir = 1'b1;
                state_n   = RD_DATA;
            end
            RD_DATA: begin
                bus.o_dir  = 1'b1;
                bus.o_data = reg_rdata;
                state_n    = RD_END;
            end
            RD_END:
                state_n = IDLE;
            TX: begin
                bus.o_nxt = 1'b1;
                if (bus.i_stp) state_n = IDLE;
            end
            RX_TURN: begin
                bus.o_dir = 1'b1;
                bus.o_nxt = 1'b1;
                state_n   = RX_DATA;
            end
            RX_DATA: begin
                bus.o_dir = 1'b1;
                if (bus.i_rx_valid) begin
                    bus.o_nxt      = 1'b1;
                    bus.o_rx_ready = 1'b1;
                    bus.o_data     = bus.i_rx_data;
                    if (bus.i_rx_last) state_n = RX_CMD_END;
                end else begin
                    bus.o_data = RXCMD_IDLE;
                end
            end
            RX_CMD_END: begin
                bus.o_dir  = 1'b1;
                bus.o_data = RXCMD_IDLE;
                state_n    = TURN_BACK;
            end
            RXC_TURN: begin
                bus.o_dir = 1'b1;
                state_n   = RXC_DATA;
            end
            RXC_DATA: begin
                bus.o_dir         = 1'b1;
                bus.o_data        = bus.i_rxcmd;
                bus.o_rxcmd_ready = 1'b1;
                state_n           = TURN_BACK;
            end
            TURN_BACK:
                state_n = IDLE;
            default:
                state_n = IDLE;
        endcase
        if (phy_reset) state_n = IDLE;
    end

endmodule
